// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side update and statistics signals of the branch predictor.
// The predictor is the slave; the pipeline (or a bench) drives it as master.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] lookup_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_npc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_is_jump;
    logic [XLEN-1:0] upd_target;
    logic            upd_mispred;
    logic            flush_all;
    logic [31:0]     stat_updates;
    logic [31:0]     stat_mispred;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
               upd_target, upd_mispred, flush_all,
        input  pred_taken, pred_npc, stat_updates, stat_mispred
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
               upd_target, upd_mispred, flush_all,
        output pred_taken, pred_npc, stat_updates, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// combinational lookup, single registered update port and two wrap-around statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned XLEN     = 32
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bus
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    typedef logic [CTR_BITS-1:0] ctr_t;
    localparam ctr_t CTR_WT  = ctr_t'(1 << (CTR_BITS - 1));
    localparam ctr_t CTR_WNT = ctr_t'((1 << (CTR_BITS - 1)) - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    logic [ENTRIES-1:0] jump_q;
    logic [31:0]        stat_updates_q;
    logic [31:0]        stat_mispred_q;

    logic [IDX-1:0]  lidx;
    logic [TAGW-1:0] ltag;
    logic [IDX-1:0]  uidx;
    logic [TAGW-1:0] utag;
    logic            lhit;
    logic            uhit;
    logic            unused_pc_bits;

    assign lidx = bus.lookup_pc[IDX+1:2];
    assign ltag = bus.lookup_pc[XLEN-1:IDX+2];
    assign uidx = bus.upd_pc[IDX+1:2];
    assign utag = bus.upd_pc[XLEN-1:IDX+2];
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    always_comb begin
        lhit           = valid_q[lidx] && (tag_q[lidx] == ltag);
        uhit           = valid_q[uidx] && (tag_q[uidx] == utag);
        bus.pred_taken = lhit && (jump_q[lidx] || ctr_q[lidx][CTR_BITS-1]);
        bus.pred_npc   = bus.pred_taken ? target_q[lidx] : bus.lookup_pc + XLEN'(4);
    end

    // Flush has priority over a same-cycle update for table state only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (bus.flush_all) begin
            valid_q <= '0;
        end else if (bus.upd_valid) begin
            if (uhit) begin
                if (bus.upd_taken) begin
                    if (ctr_q[uidx] != '1) ctr_q[uidx] <= ctr_q[uidx] + ctr_t'(1);
                    target_q[uidx] <= bus.upd_target;
                    jump_q[uidx]   <= bus.upd_is_jump;
                end else if (ctr_q[uidx] != '0) begin
                    ctr_q[uidx] <= ctr_q[uidx] - ctr_t'(1);
                end
            end else if (bus.upd_taken) begin
                valid_q[uidx]  <= 1'b1;
                tag_q[uidx]    <= utag;
                target_q[uidx] <= bus.upd_target;
                jump_q[uidx]   <= bus.upd_is_jump;
                ctr_q[uidx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_updates_q <= '0;
            stat_mispred_q <= '0;
        end else if (bus.upd_valid) begin
            stat_updates_q <= stat_updates_q + 32'd1;
            if (bus.upd_mispred) stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.stat_updates = stat_updates_q;
    assign bus.stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected lookup/statistics
// values into a queue, a negedge monitor pops and compares them.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(
        .ENTRIES (16),
        .CTR_BITS(2),
        .XLEN    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] npc;
        logic [31:0] su;
        logic [31:0] sm;
    } exp_t;

    exp_t        sb[$];
    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] exp_upd = '0;
    logic [31:0] exp_mis = '0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (bus.pred_taken !== e.taken || bus.pred_npc !== e.npc ||
                bus.stat_updates !== e.su || bus.stat_mispred !== e.sm) begin
                fails++;
                $display("FAIL %s: got taken=%0b npc=%h upd=%h mis=%h, expected taken=%0b npc=%h upd=%h mis=%h",
                         e.name, bus.pred_taken, bus.pred_npc, bus.stat_updates, bus.stat_mispred,
                         e.taken, e.npc, e.su, e.sm);
            end
        end
    end

    task automatic push(input string name, input logic et, input logic [31:0] enpc);
        exp_t e;
        e.name  = name;
        e.taken = et;
        e.npc   = enpc;
        e.su    = exp_upd;
        e.sm    = exp_mis;
        sb.push_back(e);
    endtask

    // Called just after a rising edge: drive one cycle, expect pre-update lookup.
    task automatic step(input string name, input logic v, input logic [31:0] pc,
                        input logic tk, input logic jmp, input logic [31:0] tgt,
                        input logic mis, input logic fl, input logic [31:0] lpc,
                        input logic et, input logic [31:0] enpc);
        bus.upd_valid   = v;
        bus.upd_pc      = pc;
        bus.upd_taken   = tk;
        bus.upd_is_jump = jmp;
        bus.upd_target  = tgt;
        bus.upd_mispred = mis;
        bus.flush_all   = fl;
        bus.lookup_pc   = lpc;
        push(name, et, enpc);
        @(posedge clk);
        #1;
        if (v) begin
            exp_upd = exp_upd + 32'd1;
            if (mis) exp_mis = exp_mis + 32'd1;
        end
    endtask

    task automatic look(input string name, input logic [31:0] lpc,
                        input logic et, input logic [31:0] enpc);
        step(name, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lpc, et, enpc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_is_jump = 1'b0;
        bus.upd_target  = '0;
        bus.upd_mispred = 1'b0;
        bus.flush_all   = 1'b0;
        bus.lookup_pc   = 32'h100;
        push("reset_state", 1'b0, 32'h104);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        step("alloc_miss", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h100, 1'b0, 32'h104);
        look("hit_taken", 32'h100, 1'b1, 32'h200);
        step("nt_no_bypass", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200);
        look("after_nt", 32'h100, 1'b0, 32'h104);

        step("sat_t1", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h100, 1'b0, 32'h104);
        step("sat_t2", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);
        step("sat_t3", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);
        step("sat_t4", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);
        step("sat_n1", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);
        step("sat_n2", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);
        step("sat_n3", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h104);
        step("sat_n4", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h104);
        look("ctr_floor", 32'h100, 1'b0, 32'h104);

        step("alias_alloc", 1'b1, 32'h140, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h100, 1'b0, 32'h104);
        look("alias_old_miss", 32'h100, 1'b0, 32'h104);
        look("alias_new_hit", 32'h140, 1'b1, 32'h400);
        look("low_bits_ignored", 32'h142, 1'b1, 32'h400);
        step("jal_n1", 1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h140, 1'b1, 32'h400);
        step("jal_n2", 1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h140, 1'b1, 32'h400);
        look("jal_ctr0_taken", 32'h140, 1'b1, 32'h400);
        step("miss_nt", 1'b1, 32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h140, 1'b1, 32'h400);
        look("miss_nt_kept", 32'h140, 1'b1, 32'h400);
        look("other_index", 32'h104, 1'b0, 32'h108);
        look("npc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("mispred_ignored", 1'b0, 32'h140, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h140, 1'b1, 32'h400);

        step("flush_with_upd", 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 32'h140, 1'b1, 32'h400);
        look("flush_no_alloc", 32'h300, 1'b0, 32'h304);
        look("flush_cleared", 32'h140, 1'b0, 32'h144);

        force dut.stat_mispred_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_mispred_q;
        exp_mis = 32'hFFFF_FFFF;
        look("mis_preload", 32'h140, 1'b0, 32'h144);
        step("mis_wrap", 1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h140, 1'b0, 32'h144);
        look("mis_zero", 32'h140, 1'b0, 32'h144);

        step("burst_alloc", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h100, 1'b0, 32'h104);
        step("burst_hit", 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 32'h200);

        bus.upd_valid   = 1'b1;
        bus.upd_pc      = 32'h700;
        bus.upd_taken   = 1'b1;
        bus.upd_is_jump = 1'b0;
        bus.upd_target  = 32'h800;
        bus.upd_mispred = 1'b1;
        bus.flush_all   = 1'b0;
        bus.lookup_pc   = 32'h100;
        #1;
        rst = 1'b0;
        exp_upd = '0;
        exp_mis = '0;
        push("async_reset", 1'b0, 32'h104);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        rst = 1'b1;
        look("reset_dropped_upd", 32'h700, 1'b0, 32'h704);
        look("reset_cleared", 32'h100, 1'b0, 32'h104);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
